// File: rtl/dcache_controller_pkg.sv
// dcache_controller_pkg: geometry and FSM encoding shared by the cache controller files.
package dcache_controller_pkg;
  localparam int TAG_W = 3;
  localparam int IDX_W = 3;
  localparam int OFF_W = 2;
  localparam int LINES = 8;
  localparam int BLOCK_W = 32;
  localparam int ADDR_W = TAG_W + IDX_W + OFF_W;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;
endpackage

// File: rtl/dcache_controller_if.sv
// dcache_controller_if: CPU-side and memory-side signals of the cache; slave = cache, master = environment.
interface dcache_controller_if;
  import dcache_controller_pkg::*;
  logic read;
  logic write;
  logic [ADDR_W-1:0] address;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic busywait;
  logic mem_read;
  logic mem_write;
  logic [TAG_W+IDX_W-1:0] mem_address;
  logic [BLOCK_W-1:0] mem_writedata;
  logic [BLOCK_W-1:0] mem_readdata;
  logic mem_busywait;
  modport slave (
    input read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_byte_sel.sv
// dcache_byte_sel: picks byte[offset] out of a cache block, byte0 in the low bits.
module dcache_byte_sel
  import dcache_controller_pkg::*;
(
  input  logic [BLOCK_W-1:0] block,
  input  logic [OFF_W-1:0]   offset,
  output logic [7:0]         rdata
);
  assign rdata = block[{offset, 3'b000} +: 8];
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped 8-line write-back data cache with writeback/allocate FSM.
module dcache_controller
  import dcache_controller_pkg::*;
(
  input logic clock,
  input logic reset,
  dcache_controller_if.slave bus
);
  state_e state_q, state_d;
  logic first_q, first_d;
  logic [LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [LINES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [LINES-1:0][BLOCK_W-1:0] data_q, data_d;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic hit, req, mem_done;
  assign tag = bus.address[OFF_W+IDX_W +: TAG_W];
  assign idx = bus.address[OFF_W +: IDX_W];
  assign off = bus.address[OFF_W-1:0];
  assign req = bus.read | bus.write;
  assign hit = valid_q[idx] && tag_q[idx] == tag;
  // memory may still show a stale ready in the first cycle of a request
  assign mem_done = !first_q && !bus.mem_busywait;
  assign bus.busywait = req && !(state_q == IDLE && hit);
  assign bus.mem_read = state_q == ALLOCATE;
  assign bus.mem_write = state_q == WRITEBACK;
  assign bus.mem_address = state_q == WRITEBACK ? {tag_q[idx], idx} :
                           state_q == ALLOCATE  ? {tag, idx} : '0;
  assign bus.mem_writedata = state_q == WRITEBACK ? data_q[idx] : '0;
  dcache_byte_sel u_byte_sel (
    .block  (data_q[idx]),
    .offset (off),
    .rdata  (bus.readdata)
  );
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d = tag_q;
    data_d = data_q;
    unique case (state_q)
      IDLE: begin
        if (req && !hit)
          state_d = valid_q[idx] && dirty_q[idx] ? WRITEBACK : ALLOCATE;
        else if (bus.write && hit) begin
          data_d[idx][{off, 3'b000} +: 8] = bus.writedata;
          dirty_d[idx] = 1'b1;
        end
      end
      WRITEBACK: state_d = mem_done ? ALLOCATE : WRITEBACK;
      ALLOCATE: if (mem_done) begin
        state_d = IDLE;
        data_d[idx] = bus.mem_readdata;
        tag_d[idx] = tag;
        valid_d[idx] = 1'b1;
        dirty_d[idx] = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    first_d = state_d != IDLE && state_d != state_q;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      first_q <= 1'b0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end
  always_ff @(posedge clock) begin
    tag_q <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed checks of hits, misses, eviction, first-cycle ignore and reset abort.
module tb_dcache_controller;
  logic clock = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  dcache_controller_if bus();
  dcache_controller dut (.clock(clock), .reset(reset), .bus(bus.slave));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  initial begin
    reset = 1'b0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.address = '0;
    bus.writedata = '0;
    bus.mem_readdata = '0;
    bus.mem_busywait = 1'b0;
    step(2);
    chk("rst_busywait", {31'b0, bus.busywait}, 0);
    chk("rst_mem_read", {31'b0, bus.mem_read}, 0);
    chk("rst_mem_write", {31'b0, bus.mem_write}, 0);
    chk("rst_mem_address", {26'b0, bus.mem_address}, 0);
    reset = 1'b1;
    // cold read miss at 0x25
    bus.read = 1'b1;
    bus.address = 8'h25;
    bus.mem_busywait = 1'b1;
    settle();
    chk("cold_busywait", {31'b0, bus.busywait}, 1);
    chk("cold_idle_mem_read", {31'b0, bus.mem_read}, 0);
    step();
    bus.mem_busywait = 1'b0;
    bus.mem_readdata = 32'hDDCCBBAA;
    settle();
    chk("cold_alloc_mem_read", {31'b0, bus.mem_read}, 1);
    chk("cold_alloc_mem_write", {31'b0, bus.mem_write}, 0);
    chk("cold_alloc_addr", {26'b0, bus.mem_address}, 32'h09);
    step();
    chk("cold_first_cycle_ignored", {31'b0, bus.mem_read}, 1);
    step();
    chk("cold_done_mem_read", {31'b0, bus.mem_read}, 0);
    chk("cold_done_busywait", {31'b0, bus.busywait}, 0);
    chk("cold_readdata", {24'b0, bus.readdata}, 32'hBB);
    chk("idle_mem_address", {26'b0, bus.mem_address}, 0);
    chk("idle_mem_writedata", bus.mem_writedata, 0);
    bus.address = 8'h24;
    settle();
    chk("read_off0", {24'b0, bus.readdata}, 32'hAA);
    bus.address = 8'h26;
    settle();
    chk("read_off2", {24'b0, bus.readdata}, 32'hCC);
    // write hit, zero stall
    bus.read = 1'b0;
    bus.write = 1'b1;
    bus.address = 8'h27;
    bus.writedata = 8'h5A;
    settle();
    chk("wr_hit_busywait", {31'b0, bus.busywait}, 0);
    step();
    bus.write = 1'b0;
    bus.read = 1'b1;
    settle();
    chk("rd_after_wr_busywait", {31'b0, bus.busywait}, 0);
    chk("rd_after_wr_data", {24'b0, bus.readdata}, 32'h5A);
    // dirty eviction via 0x45
    bus.address = 8'h45;
    bus.mem_busywait = 1'b1;
    settle();
    chk("evict_busywait", {31'b0, bus.busywait}, 1);
    step();
    chk("wb_mem_write", {31'b0, bus.mem_write}, 1);
    chk("wb_mem_read", {31'b0, bus.mem_read}, 0);
    chk("wb_addr", {26'b0, bus.mem_address}, 32'h09);
    chk("wb_data", bus.mem_writedata, 32'h5ACCBBAA);
    bus.mem_busywait = 1'b0;
    step();
    chk("wb_first_cycle_ignored", {31'b0, bus.mem_write}, 1);
    step();
    chk("evict_alloc_mem_read", {31'b0, bus.mem_read}, 1);
    chk("evict_alloc_mem_write", {31'b0, bus.mem_write}, 0);
    chk("evict_alloc_addr", {26'b0, bus.mem_address}, 32'h11);
    bus.mem_readdata = 32'h44332211;
    step(2);
    chk("evict_done_busywait", {31'b0, bus.busywait}, 0);
    chk("evict_readdata", {24'b0, bus.readdata}, 32'h22);
    // clean miss via 0x65: straight to allocate
    bus.address = 8'h65;
    bus.mem_readdata = 32'h88776655;
    step();
    chk("clean_mem_write", {31'b0, bus.mem_write}, 0);
    chk("clean_mem_read", {31'b0, bus.mem_read}, 1);
    chk("clean_addr", {26'b0, bus.mem_address}, 32'h19);
    step();
    chk("clean_mem_write2", {31'b0, bus.mem_write}, 0);
    step();
    chk("clean_readdata", {24'b0, bus.readdata}, 32'h66);
    chk("clean_busywait", {31'b0, bus.busywait}, 0);
    // reset while allocating 0x25
    bus.address = 8'h25;
    bus.mem_busywait = 1'b1;
    step();
    chk("rstmid_mem_read", {31'b0, bus.mem_read}, 1);
    reset = 1'b0;
    step();
    chk("rstmid_dropped", {31'b0, bus.mem_read}, 0);
    reset = 1'b1;
    settle();
    chk("rstmid_miss_again", {31'b0, bus.busywait}, 1);
    bus.mem_busywait = 1'b0;
    bus.mem_readdata = 32'hDDCCBBAA;
    step();
    chk("rstmid_realloc", {31'b0, bus.mem_read}, 1);
    step(2);
    chk("rstmid_readdata", {24'b0, bus.readdata}, 32'hBB);
    // read and write together act as a write
    bus.write = 1'b1;
    bus.writedata = 8'h11;
    settle();
    chk("rw_busywait", {31'b0, bus.busywait}, 0);
    step();
    bus.write = 1'b0;
    settle();
    chk("rw_stored", {24'b0, bus.readdata}, 32'h11);
    bus.address = 8'hA5;
    bus.mem_busywait = 1'b1;
    step();
    chk("rw_dirty_wb", {31'b0, bus.mem_write}, 1);
    chk("rw_dirty_data", bus.mem_writedata, 32'hDDCC11AA);
    bus.read = 1'b0;
    reset = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL have the port `clock`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 SHALL have the port `reset`: input, 1 bit, synchronous and active-low (0 = reset, sampled on the rising edge of `clock`).
REQ-003 SHALL have the ports `read` and `write`: inputs, 1 bit each, CPU access strobes, level-held until `busywait` drops.
REQ-004 SHALL have the port `address`: input, 8 bits, CPU byte address split as tag[7:5], index[4:2], offset[1:0].
REQ-005 SHALL have the port `writedata`: input, 8 bits, CPU store byte.
REQ-006 SHALL have the port `readdata`: output, 8 bits, CPU load byte.
REQ-007 SHALL have the port `busywait`: output, 1 bit, CPU stall.
REQ-008 SHALL have the ports `mem_read` and `mem_write`: outputs, 1 bit each, memory request strobes.
REQ-009 SHALL have the port `mem_address`: output, 6 bits, block address {tag,index}.
REQ-010 SHALL have the port `mem_writedata`: output, 32 bits, evicted block, byte0 in [7:0].
REQ-011 SHALL have the port `mem_readdata`: input, 32 bits, fetched block, byte0 in [7:0].
REQ-012 SHALL have the port `mem_busywait`: input, 1 bit, high while memory is busy.

Function
REQ-013 SHALL hold a direct-mapped store of 8 lines, each with valid, dirty, a 3-bit tag and 32 bits of data.
REQ-014 SHALL compute hit combinationally as valid[index] AND tag[index]==address[7:5].
REQ-015 SHALL drive readdata combinationally as byte[offset] of line[index] (offset 0 -> [7:0] ... 3 -> [31:24]); readdata is valid only when busywait=0.
REQ-016 SHALL drive busywait = (read|write) AND NOT (state==IDLE AND hit), combinationally.
REQ-017 SHALL use FSM states IDLE, WRITEBACK and ALLOCATE.
REQ-018 SHALL make the IDLE transitions: hit or no request -> IDLE; miss with valid&dirty victim -> WRITEBACK; otherwise -> ALLOCATE.
REQ-019 SHALL, on a write hit in IDLE, write byte[offset] and set dirty at that edge (zero-stall store).
REQ-020 SHALL, in WRITEBACK, drive mem_write=1, mem_address={stored tag,index} and mem_writedata=line data.
REQ-021 SHALL, in ALLOCATE, drive mem_read=1 and mem_address={address tag,index}.
REQ-022 SHALL ignore mem_busywait in the first cycle of WRITEBACK/ALLOCATE and sample it from the second cycle onward (registered-memory tolerance).
REQ-023 SHALL, when mem_busywait is sampled 0: WRITEBACK -> ALLOCATE; ALLOCATE -> IDLE, loading mem_readdata, tag, valid=1, dirty=0 at that edge.
REQ-024 SHALL, after a miss, complete the retried access in IDLE as a hit (read data returned / write hit applied).
REQ-025 SHALL keep mem_read and mem_write mutually exclusive and drive both 0 in IDLE.
REQ-026 SHALL treat read&write both asserted as a write.
REQ-027 SHALL leave request inputs unsampled outside IDLE; the CPU holds them stable while busywait=1.
REQ-028 SHALL drive mem_address=0 and mem_writedata=0 in IDLE.

Reset
REQ-029 SHALL, while reset=0 at a clock edge, force state=IDLE and clear all valid and dirty bits; tags and data are don't-care.
REQ-030 SHALL leave, after reset: busywait=0 (no request), mem_read=0, mem_write=0, readdata = don't-care.
REQ-031 SHALL, on reset mid-WRITEBACK/ALLOCATE, abort the transaction, drop mem_read/mem_write from the next cycle and lose the dirty data.

Structure
REQ-032 SHALL take the widths TAG_W=3, IDX_W=3, OFF_W=2, LINES=8, BLOCK_W=32 and the state encoding from a shared package.
REQ-033 SHALL place the byte-select of REQ-015 in sub-module dcache_byte_sel (32-bit block, 2-bit offset -> 8-bit byte).
REQ-034 SHALL be built as FSM, tag/valid/dirty arrays and data array within 120-400 RTL lines.

Verification
REQ-035 SHALL cover a cold read: after reset, read 0x25 -> busywait=1, ALLOCATE mem_read=1, mem_address=0x09; memory returns 0xDDCCBBAA -> IDLE, readdata=0xBB, busywait=0.
REQ-036 SHALL cover a write hit: write 0x5A to 0x27 -> busywait=0 that cycle; then read 0x27 -> 0x5A, zero stall.
REQ-037 SHALL cover a dirty eviction: read 0x45 -> WRITEBACK mem_write=1, mem_address=0x09, mem_writedata=0x5ACCBBAA, then ALLOCATE mem_address=0x11.
REQ-038 SHALL cover a clean miss: read 0x65 after the eviction -> ALLOCATE directly, mem_write never asserted.
REQ-039 SHALL cover reset mid-ALLOCATE: reset=0 with mem_busywait=1 -> mem_read=0 next cycle; read 0x25 misses again.
REQ-040 SHALL cover read=write=1 to 0x25 with writedata=0x11 on a hit -> byte stored, dirty set, busywait=0.
